sqroot_square_check_seq: RTL

//  Sequential inverse of the combinational square-root block. Takes a root

---
 rtl/sqroot_square_check_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sqroot_square_check_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sqroot_square_check_seq
//  Purpose  : Sequential checker for square-root results. Squares a root
//             candidate with a shift-add multiplier (one root bit per clock).
//             It reports the exact square, an overflow flag (square does not
//             fit in NBITS) and a bound flag (square <= original argument).
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous, active-high reset
//             in_valid   - root/arg present
//             in_ready   - block can accept (high only while idle)
//             in_root    - root candidate, RBITS wide, unsigned
//             in_arg     - original argument, NBITS wide, unsigned
//             out_valid  - result present
//             out_ready  - consumer takes result
//             out_sq     - in_root*in_root, 2*RBITS wide, exact
//             out_ovf    - out_sq > 2**NBITS-1
//             out_le     - out_sq <= in_arg
//  Revision : 1.0 - initial release
// ============================================================================
module sqroot_square_check_seq #(
  parameter int NBITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NBITS/2:0]              in_root,
  input  logic [NBITS-1:0]              in_arg,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*(NBITS/2+1)-1:0]      out_sq,
  output logic                          out_ovf,
  output logic                          out_le
);

  localparam int RBITS = NBITS / 2 + 1;
  localparam int SBITS = 2 * RBITS;
  // The counter must be able to hold RBITS itself: it marks the cycle
  // after the last partial product has been added.
  localparam int CW    = $clog2(RBITS + 1);
  localparam logic [CW-1:0] c_CNT_DONE = CW'(RBITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [RBITS-1:0]   r_mcand;
  logic [RBITS-1:0]   r_mplr;
  logic [NBITS-1:0]   r_arg;
  logic [SBITS-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;

  logic               r_out_valid;
  logic [SBITS-1:0]   r_out_sq;
  logic               r_out_ovf;
  logic               r_out_le;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_calc_last;
  logic [SBITS-1:0]   w_addend;
  logic [SBITS-1:0]   w_arg_ext;

  assign w_in_ready  = (r_state == S_IDLE);
  assign w_accept    = in_valid && w_in_ready;
  assign w_calc_last = (r_cnt == c_CNT_DONE);
  // Partial product for the current multiplier bit; the accumulator is wide
  // enough for the largest square, so the sum never wraps.
  assign w_addend    = {{RBITS{1'b0}}, r_mcand} << r_cnt;
  assign w_arg_ext   = {{(SBITS-NBITS){1'b0}}, r_arg};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_calc_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, shift-add multiply and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_arg       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sq    <= '0;
      r_out_ovf   <= 1'b0;
      r_out_le    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand <= in_root;
            r_mplr  <= in_root;
            r_arg   <= in_arg;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          if (w_calc_last) begin
            // All RBITS partial products are in; publish the result.
            r_out_sq    <= r_acc;
            r_out_ovf   <= |r_acc[SBITS-1:NBITS];
            r_out_le    <= (r_acc <= w_arg_ext);
            r_out_valid <= 1'b1;
          end else begin
            if (r_mplr[0]) begin
              r_acc <= r_acc + w_addend;
            end
            r_mplr <= r_mplr >> 1;
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // Result fields keep their values after the handshake; only the
          // qualifier drops.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sq    = r_out_sq;
  assign out_ovf   = r_out_ovf;
  assign out_le    = r_out_le;

endmodule
`default_nettype wire
